// File: rtl/adc_framer_pkg.sv
// Shared tags, FSM states and header field layout for adc_burst_framer.
// ADC_OVERRANGE_COUNT_EN adds the TRAILER state for the overrange-count word.
package adc_framer_pkg;

   localparam int LANE_W = 16;

   localparam int TAG_FILL_HDR = 1;
   localparam int TAG_WF_HDR   = 2;
   localparam int TAG_DATA     = 3;
   localparam int TAG_CKSUM    = 4;
   localparam int TAG_OVR      = 5;

   localparam logic [1:0] HDR_MARK     = 2'b01;
   localparam int         HDR_MARK_LSB = 126;

   // Fill header layout
   localparam int FH_FILL_NUM_LSB  = 0;
   localparam int FH_FILL_TYPE_LSB = 24;
   localparam int FH_FLAG_BIT      = 26;
   localparam int FH_TOTAL_LSB     = 27;
   localparam int FH_NUM_WF_LSB    = 76;
   localparam int FH_CHAN_LSB      = 110;

   // Waveform header layout
   localparam int WH_BPW_LSB       = 0;
   localparam int WH_PRE_TRIG_LSB  = 11;
   localparam int WH_FILL_TYPE_LSB = 23;
   localparam int WH_FLAG_BIT      = 25;
   localparam int WH_ADDR_LSB      = 26;
   localparam int WH_WF_CNT_LSB    = 52;
   localparam int WH_CHAN_LSB      = 98;

   typedef enum logic [2:0] {
      IDLE,
      FILL_HDR,
      WF_HDR,
      DATA,
      CKSUM,
`ifdef ADC_OVERRANGE_COUNT_EN
      TRAILER,
`endif
      FIN
   } state_e;

   function automatic logic [127:0] fill_hdr(
      input logic [23:0] fill_num,
      input logic [1:0]  fill_type,
      input logic [22:0] total,
      input logic [22:0] num_wf,
      input logic [15:0] chan
   );
      logic [127:0] h;
      h = '0;
      h[FH_FILL_NUM_LSB  +: 24] = fill_num;
      h[FH_FILL_TYPE_LSB +: 2]  = fill_type;
      h[FH_FLAG_BIT]            = 1'b1;
      h[FH_TOTAL_LSB     +: 23] = total;
      h[FH_NUM_WF_LSB    +: 23] = num_wf;
      h[FH_CHAN_LSB      +: 16] = chan;
      h[HDR_MARK_LSB     +: 2]  = HDR_MARK;
      return h;
   endfunction

   function automatic logic [127:0] wf_hdr(
      input logic [10:0] bpw,
      input logic [11:0] pre_trig,
      input logic [1:0]  fill_type,
      input logic [25:0] start_addr,
      input logic [22:0] wf_cnt,
      input logic [15:0] chan
   );
      logic [127:0] h;
      h = '0;
      h[WH_BPW_LSB       +: 11] = bpw;
      h[WH_PRE_TRIG_LSB  +: 12] = pre_trig;
      h[WH_FILL_TYPE_LSB +: 2]  = fill_type;
      h[WH_FLAG_BIT]            = 1'b1;
      h[WH_ADDR_LSB      +: 26] = start_addr;
      h[WH_WF_CNT_LSB    +: 23] = wf_cnt;
      h[WH_CHAN_LSB      +: 16] = chan;
      h[HDR_MARK_LSB     +: 2]  = HDR_MARK;
      return h;
   endfunction

endpackage

// File: rtl/adc_lane_pack.sv
// Packs one ADC beat into 16-bit sign-extended lanes (overrange bit dropped)
// and counts how many samples of the beat flagged overrange.
module adc_lane_pack
   import adc_framer_pkg::*;
#(
   parameter int SAMPLE_W = 12,
   parameter int SAMPLES  = 8,
   parameter int CNT_W    = $clog2(SAMPLES + 1)
) (
   input  logic [SAMPLES*(SAMPLE_W+1)-1:0] adc_dat,
   output logic [SAMPLES*LANE_W-1:0]       payload,
   output logic [CNT_W-1:0]                beat_ovr
);

   // NOTE: every variable written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      payload  = '0;
      beat_ovr = '0;
      for (int k = 0; k < SAMPLES; k++) begin
         payload[k*LANE_W +: LANE_W] =
            LANE_W'($signed(adc_dat[k*(SAMPLE_W+1)+1 +: SAMPLE_W]));
         beat_ovr = beat_ovr + CNT_W'(adc_dat[k*(SAMPLE_W+1)]);
      end
   end

endmodule

// File: rtl/adc_burst_framer.sv
// Fill framer: fill header, per-waveform header + data bursts, checksum, into a
// single tagged output register. ADC_OVERRANGE_COUNT_EN appends an overrange trailer.
module adc_burst_framer
   import adc_framer_pkg::*;
#(
   parameter int SAMPLE_W = 12,
   parameter int SAMPLES  = 8,
   parameter int TAG_W    = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [22:0]                         num_waveforms,
   input  logic [10:0]                         bursts_per_wf,
   input  logic [11:0]                         pre_trig,
   input  logic [23:0]                         fill_num,
   input  logic [1:0]                          fill_type,
   input  logic [15:0]                         channel_tag,
   input  logic [SAMPLES*(SAMPLE_W+1)-1:0]     adc_dat,
   input  logic                                adc_valid,
   output logic                                adc_ready,
   output logic [TAG_W+SAMPLES*LANE_W-1:0]     out_dat,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic                                busy,
   output logic                                done
);

   localparam int DW    = SAMPLES * LANE_W;
   localparam int CNT_W = $clog2(SAMPLES + 1);
`ifdef ADC_OVERRANGE_COUNT_EN
   localparam logic [22:0] TOTAL_BASE = 23'd3;
`else
   localparam logic [22:0] TOTAL_BASE = 23'd2;
`endif

   state_e            state_q, state_d;
   logic [22:0]       num_wf_q, num_wf_d;
   logic [10:0]       bpw_q, bpw_d;
   logic [11:0]       pre_trig_q, pre_trig_d;
   logic [23:0]       fill_num_q, fill_num_d;
   logic [1:0]        fill_type_q, fill_type_d;
   logic [15:0]       chan_q, chan_d;
   logic [22:0]       total_q, total_d;
   logic [22:0]       wf_cnt_q, wf_cnt_d;
   logic [10:0]       burst_cnt_q, burst_cnt_d;
   logic [22:0]       adr_cnt_q, adr_cnt_d;
   logic [DW-1:0]     cksum_q, cksum_d;
   logic [TAG_W+DW-1:0] out_dat_q, out_dat_d;
   logic              out_valid_q, out_valid_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              slot_free, last_wf, last_burst;
   logic              ld, ld_sum;
   logic [TAG_W-1:0]  ld_tag;
   logic [DW-1:0]     ld_pay;
   logic [DW-1:0]     lane_pay;

`ifdef ADC_OVERRANGE_COUNT_EN
   logic [15:0]       ovr_cnt_q, ovr_cnt_d;
   logic [CNT_W-1:0]  beat_ovr;
   logic [16:0]       ovr_sum;

   adc_lane_pack #(.SAMPLE_W(SAMPLE_W), .SAMPLES(SAMPLES), .CNT_W(CNT_W)) u_pack (
      .adc_dat  (adc_dat),
      .payload  (lane_pay),
      .beat_ovr (beat_ovr)
   );
`else
   adc_lane_pack #(.SAMPLE_W(SAMPLE_W), .SAMPLES(SAMPLES), .CNT_W(CNT_W)) u_pack (
      .adc_dat  (adc_dat),
      .payload  (lane_pay),
      .beat_ovr ()
   );
`endif

   assign slot_free  = !out_valid_q || out_ready;
   assign last_wf    = (wf_cnt_q == num_wf_q - 23'd1);
   assign last_burst = (burst_cnt_q == bpw_q - 11'd1);

   always_comb begin
      state_d     = state_q;
      num_wf_d    = num_wf_q;
      bpw_d       = bpw_q;
      pre_trig_d  = pre_trig_q;
      fill_num_d  = fill_num_q;
      fill_type_d = fill_type_q;
      chan_d      = chan_q;
      total_d     = total_q;
      wf_cnt_d    = wf_cnt_q;
      burst_cnt_d = burst_cnt_q;
      adr_cnt_d   = adr_cnt_q;
      cksum_d     = cksum_q;
      out_dat_d   = out_dat_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      adc_ready   = 1'b0;
      ld          = 1'b0;
      ld_sum      = 1'b0;
      ld_tag      = '0;
      ld_pay      = '0;
`ifdef ADC_OVERRANGE_COUNT_EN
      ovr_cnt_d   = ovr_cnt_q;
      ovr_sum     = {1'b0, ovr_cnt_q} + 17'(beat_ovr);
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               num_wf_d    = num_waveforms;
               bpw_d       = bursts_per_wf;
               pre_trig_d  = pre_trig;
               fill_num_d  = fill_num;
               fill_type_d = fill_type;
               chan_d      = channel_tag;
               total_d     = num_waveforms * (23'(bursts_per_wf) + 23'd1) + TOTAL_BASE;
               cksum_d     = '0;
               wf_cnt_d    = '0;
               burst_cnt_d = '0;
               adr_cnt_d   = '0;
`ifdef ADC_OVERRANGE_COUNT_EN
               ovr_cnt_d   = '0;
`endif
               busy_d      = 1'b1;
               state_d     = FILL_HDR;
            end
         end
         FILL_HDR: begin
            if (slot_free) begin
               ld      = 1'b1;
               ld_sum  = 1'b1;
               ld_tag  = TAG_W'(TAG_FILL_HDR);
               ld_pay  = DW'(fill_hdr(fill_num_q, fill_type_q, total_q, num_wf_q, chan_q));
               state_d = (num_wf_q != '0) ? WF_HDR : CKSUM;
            end
         end
         WF_HDR: begin
            if (slot_free) begin
               ld     = 1'b1;
               ld_sum = 1'b1;
               ld_tag = TAG_W'(TAG_WF_HDR);
               ld_pay = DW'(wf_hdr(bpw_q, pre_trig_q, fill_type_q, {adr_cnt_q, 3'b000},
                                   wf_cnt_q, chan_q));
               if (bpw_q != '0) begin
                  burst_cnt_d = '0;
                  state_d     = DATA;
               end else if (last_wf) begin
                  state_d = CKSUM;
               end else begin
                  wf_cnt_d = wf_cnt_q + 23'd1;
               end
            end
         end
         DATA: begin
            adc_ready = slot_free;
            if (adc_valid && slot_free) begin
               ld     = 1'b1;
               ld_sum = 1'b1;
               ld_tag = TAG_W'(TAG_DATA);
               ld_pay = lane_pay;
`ifdef ADC_OVERRANGE_COUNT_EN
               ovr_cnt_d = ovr_sum[16] ? 16'hFFFF : ovr_sum[15:0];
`endif
               if (last_burst) begin
                  burst_cnt_d = '0;
                  if (last_wf) begin
                     state_d = CKSUM;
                  end else begin
                     wf_cnt_d = wf_cnt_q + 23'd1;
                     state_d  = WF_HDR;
                  end
               end else begin
                  burst_cnt_d = burst_cnt_q + 11'd1;
               end
            end
         end
         CKSUM: begin
            if (slot_free) begin
               ld     = 1'b1;
               ld_tag = TAG_W'(TAG_CKSUM);
               ld_pay = cksum_q;
`ifdef ADC_OVERRANGE_COUNT_EN
               state_d = TRAILER;
`else
               state_d = FIN;
`endif
            end
         end
`ifdef ADC_OVERRANGE_COUNT_EN
         TRAILER: begin
            // slot_free here means the checksum word is leaving this cycle.
            if (slot_free) begin
               ld      = 1'b1;
               ld_tag  = TAG_W'(TAG_OVR);
               ld_pay  = DW'(ovr_cnt_q);
               state_d = FIN;
            end
         end
`endif
         FIN: begin
            if (out_valid_q && out_ready) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (ld) begin
         out_dat_d   = {ld_tag, ld_pay};
         out_valid_d = 1'b1;
         adr_cnt_d   = adr_cnt_q + 23'd1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
      if (ld_sum) begin
         cksum_d = cksum_q ^ ld_pay;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its pre-edge inputs regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         num_wf_q    <= '0;
         bpw_q       <= '0;
         pre_trig_q  <= '0;
         fill_num_q  <= '0;
         fill_type_q <= '0;
         chan_q      <= '0;
         total_q     <= '0;
         wf_cnt_q    <= '0;
         burst_cnt_q <= '0;
         adr_cnt_q   <= '0;
         cksum_q     <= '0;
         out_dat_q   <= '0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef ADC_OVERRANGE_COUNT_EN
         ovr_cnt_q   <= '0;
`endif
      end else begin
         state_q     <= state_d;
         num_wf_q    <= num_wf_d;
         bpw_q       <= bpw_d;
         pre_trig_q  <= pre_trig_d;
         fill_num_q  <= fill_num_d;
         fill_type_q <= fill_type_d;
         chan_q      <= chan_d;
         total_q     <= total_d;
         wf_cnt_q    <= wf_cnt_d;
         burst_cnt_q <= burst_cnt_d;
         adr_cnt_q   <= adr_cnt_d;
         cksum_q     <= cksum_d;
         out_dat_q   <= out_dat_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef ADC_OVERRANGE_COUNT_EN
         ovr_cnt_q   <= ovr_cnt_d;
`endif
      end
   end

   assign out_dat   = out_dat_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_adc_burst_framer.sv
// Scoreboard bench for adc_burst_framer: a bench-side model queues every
// expected output word per fill; the monitor pops and compares on each handshake.
module tb_adc_burst_framer;

   localparam int SAMPLE_W = 12;
   localparam int SAMPLES  = 8;
   localparam int TAG_W    = 4;
   localparam int DW       = SAMPLES * 16;
   localparam int AW       = SAMPLES * (SAMPLE_W + 1);
   localparam int OW       = TAG_W + DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [22:0]   num_waveforms = '0;
   logic [10:0]   bursts_per_wf = '0;
   logic [11:0]   pre_trig = '0;
   logic [23:0]   fill_num = '0;
   logic [1:0]    fill_type = '0;
   logic [15:0]   channel_tag = '0;
   logic [AW-1:0] adc_dat = '0;
   logic          adc_valid = 1'b0;
   logic          adc_ready;
   logic [OW-1:0] out_dat;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          busy;
   logic          done;

   adc_burst_framer #(.SAMPLE_W(SAMPLE_W), .SAMPLES(SAMPLES), .TAG_W(TAG_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .num_waveforms (num_waveforms),
      .bursts_per_wf (bursts_per_wf),
      .pre_trig      (pre_trig),
      .fill_num      (fill_num),
      .fill_type     (fill_type),
      .channel_tag   (channel_tag),
      .adc_dat       (adc_dat),
      .adc_valid     (adc_valid),
      .adc_ready     (adc_ready),
      .out_dat       (out_dat),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .busy          (busy),
      .done          (done)
   );

   always #5 clk = ~clk;

   logic [OW-1:0] exp_q[$];
   logic [AW-1:0] adc_q[$];
   int            n_cmp = 0;
   int            n_bad = 0;
   int            done_cnt = 0;
   int            words = 0;
   int            ready_mode = 0;
   int            cyc = 0;
   logic          prev_stall = 1'b0;
   logic [OW-1:0] prev_dat = '0;

   logic [23:0]   c_fill_num;
   logic [1:0]    c_fill_type;
   logic [15:0]   c_chan;
   logic [11:0]   c_pre;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_fill_hdr(input int nwf, input logic [22:0] tot);
      logic [DW-1:0] h;
      h = '0;
      h[23:0]    = c_fill_num;
      h[25:24]   = c_fill_type;
      h[26]      = 1'b1;
      h[49:27]   = tot;
      h[98:76]   = 23'(nwf);
      h[125:110] = c_chan;
      h[127:126] = 2'b01;
      return h;
   endfunction

   function automatic logic [DW-1:0] m_wf_hdr(input int bpw, input int wf, input int adr);
      logic [DW-1:0] h;
      logic [22:0]   a;
      a = 23'(adr);
      h = '0;
      h[10:0]    = 11'(bpw);
      h[22:11]   = c_pre;
      h[24:23]   = c_fill_type;
      h[25]      = 1'b1;
      h[51:26]   = {a, 3'b000};
      h[74:52]   = 23'(wf);
      h[113:98]  = c_chan;
      h[127:126] = 2'b01;
      return h;
   endfunction

   // kind 0: random data, overrange on the first 5 samples of the fill
   // kind 1: all zero except beat 1 sample 0 = -1; kind 2: fully random
   task automatic make_beat(input int kind, input int beat, output logic [AW-1:0] raw,
                            output logic [DW-1:0] pay, output int nb);
      logic [SAMPLE_W-1:0] d;
      logic                o;
      raw = '0;
      pay = '0;
      nb  = 0;
      for (int k = 0; k < SAMPLES; k++) begin
         case (kind)
            0: begin
               d = SAMPLE_W'($urandom);
               o = ((beat * SAMPLES + k) < 5);
            end
            1: begin
               d = (beat == 1 && k == 0) ? 12'hFFF : 12'h000;
               o = 1'b0;
            end
            default: begin
               d = SAMPLE_W'($urandom);
               o = 1'($urandom_range(0, 1));
            end
         endcase
         raw[k*(SAMPLE_W+1) +: SAMPLE_W+1] = {d, o};
         pay[k*16 +: 16] = {{(16-SAMPLE_W){d[SAMPLE_W-1]}}, d};
         nb += int'(o);
      end
   endtask

   task automatic prep_fill(input int nwf, input int bpw, input int kind, input int rmode,
                            output int n_words);
      logic [DW-1:0] cks;
      logic [DW-1:0] pay;
      logic [AW-1:0] raw;
      logic [22:0]   tot;
      int            adr, ovr, beat, nb;
      ready_mode  = rmode;
      c_fill_num  = 24'($urandom);
      c_fill_type = 2'($urandom);
      c_chan      = 16'($urandom);
      c_pre       = 12'($urandom);
      tot = 23'(2 + nwf * (1 + bpw));
`ifdef ADC_OVERRANGE_COUNT_EN
      tot = tot + 23'd1;
`endif
      cks  = '0;
      adr  = 0;
      ovr  = 0;
      beat = 0;
      pay = m_fill_hdr(nwf, tot);
      exp_q.push_back({4'd1, pay});
      cks ^= pay;
      adr++;
      for (int w = 0; w < nwf; w++) begin
         pay = m_wf_hdr(bpw, w, adr);
         exp_q.push_back({4'd2, pay});
         cks ^= pay;
         adr++;
         for (int b = 0; b < bpw; b++) begin
            make_beat(kind, beat, raw, pay, nb);
            adc_q.push_back(raw);
            exp_q.push_back({4'd3, pay});
            cks ^= pay;
            adr++;
            ovr += nb;
            beat++;
         end
      end
      exp_q.push_back({4'd4, cks});
      n_words = adr + 1;
`ifdef ADC_OVERRANGE_COUNT_EN
      exp_q.push_back({4'd5, DW'((ovr > 65535) ? 16'hFFFF : 16'(ovr))});
      n_words++;
`endif
      done_cnt = 0;
      @(posedge clk); #1;
      num_waveforms = 23'(nwf);
      bursts_per_wf = 11'(bpw);
      pre_trig      = c_pre;
      fill_num      = c_fill_num;
      fill_type     = c_fill_type;
      channel_tag   = c_chan;
      start         = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      check("busy_after_start", busy, 1'b1);
   endtask

   task automatic run_fill(input string name, input int nwf, input int bpw, input int kind,
                           input int rmode);
      int w0, n_exp;
      int t;
      w0 = words;
      prep_fill(nwf, bpw, kind, rmode, n_exp);
      t = 0;
      while ((exp_q.size() != 0 || done_cnt == 0) && t < 4000) begin
         @(posedge clk);
         t++;
         if (rmode == 1 && t == 6) begin
            // a second start with different config must be ignored mid-fill
            #1;
            num_waveforms = 23'd7;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            t++;
         end
      end
      check({name, "_timeout"}, t < 4000, 1'b1);
      repeat (3) @(negedge clk);
      check({name, "_words"}, words - w0, n_exp);
      check({name, "_done_pulses"}, done_cnt, 1);
      check({name, "_busy_idle"}, busy, 1'b0);
      check({name, "_adc_drained"}, adc_q.size(), 0);
   endtask

   // Input driver: changes inputs 1 time unit after the active edge.
   initial forever begin
      @(posedge clk); #1;
      cyc++;
      out_ready = (ready_mode == 0) ? 1'b1 : (cyc % 3 == 0);
      adc_valid = (adc_q.size() != 0);
      adc_dat   = adc_valid ? adc_q[0] : '0;
   end

   // Monitor: samples on the falling edge, ahead of the edge that commits.
   initial forever begin
      @(negedge clk);
      if (done) done_cnt++;
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) check("stall_hold", {out_valid, out_dat}, {1'b1, prev_dat});
         if (out_valid && !out_ready) check("adc_ready_stall", adc_ready, 1'b0);
         if (adc_valid && adc_ready && adc_q.size() != 0) void'(adc_q.pop_front());
         if (out_valid && out_ready) begin
            words++;
            check("word_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) check($sformatf("word%0d", words), out_dat, exp_q.pop_front());
         end
         prev_stall = out_valid && !out_ready;
         prev_dat   = out_dat;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      int t;
      int w0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_dat", out_dat, '0);
      check("rst_adc_ready", adc_ready, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;

      run_fill("basic", 2, 3, 0, 0);
      run_fill("neg_lane", 2, 3, 1, 0);
      run_fill("stall", 3, 2, 2, 1);
      run_fill("no_wf", 0, 3, 2, 0);
      run_fill("no_burst", 2, 0, 2, 1);

      // Abort a fill mid-DATA with a one-cycle reset.
      w0 = words;
      prep_fill(2, 4, 2, 0, n);
      t = 0;
      while (words - w0 < 4 && t < 500) begin
         @(negedge clk);
         t++;
      end
      check("abort_reach_data", t < 500, 1'b1);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp_q.delete();
      adc_q.delete();
      @(negedge clk);
      check("abort_out_valid", out_valid, 1'b0);
      check("abort_busy", busy, 1'b0);
      check("abort_adc_ready", adc_ready, 1'b0);
      repeat (5) @(negedge clk);
      check("abort_no_done", done_cnt, 0);
      check("abort_quiet", out_valid, 1'b0);

      run_fill("after_abort", 1, 2, 2, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
